// File: rtl/adc_capture_buffer_pkg.sv
// Shared constants, state encoding and word packing for the ADC capture buffer.
package adc_capture_pkg;

    localparam logic [1:0] MODE_CONT   = 2'd0;
    localparam logic [1:0] MODE_SINGLE = 2'd1;
    localparam logic [1:0] MODE_TRIG   = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    // Host word layout: channel tag in the top nibble, zero-extended code below.
    function automatic logic [15:0] pack_word(input logic [3:0] ch, input logic [11:0] code);
        return {ch, code};
    endfunction

endpackage

// File: rtl/adc_capture_buffer_if.sv
// Host read-side bus of the capture buffer; master is the host, slave is the buffer.
interface adc_capture_buffer_if #(
    parameter int DEPTH_LOG2 = 10
);
    logic                  rd_en;
    logic [15:0]           rd_data;
    logic                  rd_valid;
    logic [DEPTH_LOG2:0]   word_count;
    logic                  empty;
    logic                  full;

    modport master (
        output rd_en,
        input  rd_data, rd_valid, word_count, empty, full
    );

    modport slave (
        input  rd_en,
        output rd_data, rd_valid, word_count, empty, full
    );
endinterface

// File: rtl/adc_capture_buffer_fifo.sv
// Single-clock circular word buffer with registered read data and an occupancy count.
module capture_sync_fifo #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                push,
    input  logic [15:0]         din,
    input  logic                pop,
    output logic [15:0]         dout,
    output logic                dout_valid,
    output logic [DEPTH_LOG2:0] count,
    output logic                full,
    output logic                empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [15:0]           dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  push_ok, pop_ok;

    assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign count      = count_q;

    // Pointer, count and read-register updates; a flush returns everything to zero.
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            dout_d   = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d     = rd_ptr_q + 1'b1;
                dout_d       = mem[rd_ptr_q];
                dout_valid_d = 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage array carries no reset; only the pointers define which words are live.
    always_ff @(posedge clk) begin
        if (push_ok && !clear) begin
            mem[wr_ptr_q] <= din;
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

endmodule

// File: rtl/adc_capture_buffer.sv
// Decimating, optionally triggered multi-channel ADC capture into a tagged word FIFO.
module adc_capture_buffer
    import adc_capture_pkg::*;
#(
    parameter int PRECISION   = 10,
    parameter int CHANNELS    = 2,
    parameter int DEPTH_LOG2  = 10,
    parameter int DECIM_WIDTH = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_valid,
    input  logic [CHANNELS*PRECISION-1:0] sample_data,
    input  logic                          arm,
    input  logic                          stop,
    input  logic [1:0]                    mode,
    input  logic [COUNT_WIDTH-1:0]        capture_len,
    input  logic [DECIM_WIDTH-1:0]        decim,
    input  logic [PRECISION-1:0]          trig_level,
    input  logic                          clear,
    adc_capture_buffer_if.slave           host,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          busy,
    output logic                          done,
    output logic [COUNT_WIDTH-1:0]        sample_total
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    state_t                        state_q, state_d;
    logic [1:0]                    cfg_mode_q, cfg_mode_d;
    logic [COUNT_WIDTH-1:0]        cfg_len_q, cfg_len_d;
    logic [DECIM_WIDTH-1:0]        cfg_decim_q, cfg_decim_d;
    logic [PRECISION-1:0]          cfg_trig_q, cfg_trig_d;
    logic [DECIM_WIDTH-1:0]        decim_cnt_q, decim_cnt_d;
    logic [PRECISION-1:0]          prev_ch0_q, prev_ch0_d;
    logic [COUNT_WIDTH-1:0]        total_q, total_d;
    logic                          ser_active_q, ser_active_d;
    logic [IDX_W-1:0]              ser_idx_q, ser_idx_d;
    logic [CHANNELS*PRECISION-1:0] ser_data_q, ser_data_d;
    logic                          stop_pend_q, stop_pend_d;
    logic                          overflow_q, overflow_d;
    logic                          underflow_q, underflow_d;

    logic                  in_busy, kept, limited, quota_reached, trig_hit;
    logic                  ser_last, ser_free, room_ok, stopping;
    logic                  want_store, accept, arm_go;
    logic [PRECISION-1:0]  cur_ch0, ser_code;
    logic [15:0]           push_word;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic                  fifo_empty, fifo_full;
    int                    pending_words;

    assign cur_ch0       = sample_data[PRECISION-1:0];
    assign in_busy       = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
    assign kept          = sample_valid && in_busy && (decim_cnt_q == '0);
    assign limited       = (cfg_mode_q == MODE_SINGLE) || (cfg_mode_q == MODE_TRIG);
    assign quota_reached = limited && (total_q >= cfg_len_q);
    assign trig_hit      = (state_q == WAIT_TRIG) && kept &&
                           (prev_ch0_q < cfg_trig_q) && (cur_ch0 >= cfg_trig_q);
    assign ser_last      = ser_active_q && (ser_idx_q == LAST_IDX);
    assign ser_free      = !ser_active_q || ser_last;
    assign stopping      = stop || stop_pend_q;
    assign arm_go        = ((state_q == IDLE) || (state_q == DONE)) && arm && !stop;

    // Room is judged against the words still queued in the serialiser, not just the FIFO count,
    // so a sample accepted while the previous one drains can never overrun the buffer.
    assign pending_words = ser_active_q ? (CHANNELS - int'(ser_idx_q)) : 0;
    assign room_ok       = (int'(fifo_count) + pending_words) <= (DEPTH - CHANNELS);

    assign want_store    = kept && ((state_q == CAPTURE) || trig_hit) && !stopping && !quota_reached;
    assign accept        = want_store && ser_free && room_ok;

    assign ser_code  = ser_data_q[int'(ser_idx_q)*PRECISION +: PRECISION];
    assign push_word = pack_word(4'(ser_idx_q), 12'(ser_code));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; a capture only closes once the in-flight sample has been fully written.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: if (arm_go) state_d = (mode == MODE_TRIG) ? WAIT_TRIG : CAPTURE;
                WAIT_TRIG: begin
                    if (stop)          state_d = DONE;
                    else if (trig_hit) state_d = CAPTURE;
                end
                CAPTURE: if ((stopping || quota_reached) && ser_free) state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM status outputs.
    always_comb begin
        busy = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
        done = (state_q == DONE);
    end

    // Configuration latch, decimator, trigger history, serialiser and sticky flags.
    always_comb begin
        cfg_mode_d   = cfg_mode_q;
        cfg_len_d    = cfg_len_q;
        cfg_decim_d  = cfg_decim_q;
        cfg_trig_d   = cfg_trig_q;
        decim_cnt_d  = decim_cnt_q;
        prev_ch0_d   = prev_ch0_q;
        total_d      = total_q;
        ser_active_d = ser_active_q;
        ser_idx_d    = ser_idx_q;
        ser_data_d   = ser_data_q;
        stop_pend_d  = 1'b0;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        if (clear) begin
            cfg_mode_d   = '0;
            cfg_len_d    = '0;
            cfg_decim_d  = '0;
            cfg_trig_d   = '0;
            decim_cnt_d  = '0;
            prev_ch0_d   = '0;
            total_d      = '0;
            ser_active_d = 1'b0;
            ser_idx_d    = '0;
            ser_data_d   = '0;
            overflow_d   = 1'b0;
            underflow_d  = 1'b0;
        end else begin
            if (arm_go) begin
                cfg_mode_d  = (mode == 2'd3) ? MODE_CONT : mode;
                cfg_len_d   = capture_len;
                cfg_decim_d = decim;
                cfg_trig_d  = trig_level;
                decim_cnt_d = '0;
                total_d     = '0;
            end
            if (sample_valid && in_busy) begin
                decim_cnt_d = (decim_cnt_q >= cfg_decim_q) ? '0 : decim_cnt_q + 1'b1;
            end
            if (kept) begin
                prev_ch0_d = cur_ch0;
            end
            if (ser_active_q) begin
                if (ser_last) begin
                    ser_active_d = 1'b0;
                    ser_idx_d    = '0;
                end else begin
                    ser_idx_d = ser_idx_q + 1'b1;
                end
            end
            if (accept) begin
                ser_active_d = 1'b1;
                ser_idx_d    = '0;
                ser_data_d   = sample_data;
                total_d      = total_q + 1'b1;
            end
            stop_pend_d = (state_q == CAPTURE) && (state_d == CAPTURE) && stopping;
            if (want_store && !accept) overflow_d = 1'b1;
            if (host.rd_en && fifo_empty) underflow_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_mode_q   <= '0;
            cfg_len_q    <= '0;
            cfg_decim_q  <= '0;
            cfg_trig_q   <= '0;
            decim_cnt_q  <= '0;
            prev_ch0_q   <= '0;
            total_q      <= '0;
            ser_active_q <= 1'b0;
            ser_idx_q    <= '0;
            ser_data_q   <= '0;
            stop_pend_q  <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            cfg_mode_q   <= cfg_mode_d;
            cfg_len_q    <= cfg_len_d;
            cfg_decim_q  <= cfg_decim_d;
            cfg_trig_q   <= cfg_trig_d;
            decim_cnt_q  <= decim_cnt_d;
            prev_ch0_q   <= prev_ch0_d;
            total_q      <= total_d;
            ser_active_q <= ser_active_d;
            ser_idx_q    <= ser_idx_d;
            ser_data_q   <= ser_data_d;
            stop_pend_q  <= stop_pend_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    capture_sync_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .push       (ser_active_q),
        .din        (push_word),
        .pop        (host.rd_en),
        .dout       (host.rd_data),
        .dout_valid (host.rd_valid),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign host.word_count = fifo_count;
    assign host.empty      = fifo_empty;
    assign host.full       = fifo_full;
    assign overflow        = overflow_q;
    assign underflow       = underflow_q;
    assign sample_total    = total_q;

endmodule
